quickdev_cpld_core: RTL and testbench

CPLD core that bridges the AVR controller to the cartridge SRAM, with a SNES passthrough mode.
- AVR loads a 21-bit SRAM address serially through a shift register and steps it with a counter strobe.
- AVR reads and writes single bytes through a registered bus FSM.
- A 7-bit command port can replace the discrete AVR control pins.

---
 rtl/quickdev_cpld_core.sv | 198 +++++++++++++++++++
 tb/tb_quickdev_cpld_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quickdev_cpld_core.sv
// AVR-to-SRAM bridge: serial address load, address counter, byte read/write FSM, SNES passthrough.
// Define CPLD_DEBUG_EN to expose FSM state and oe/we conflict flag on debug; otherwise debug is tied to 0.
module quickdev_cpld_core #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
) (
  input  logic              avr_clk,
  input  logic              avr_reset_n,
  inout  wire  [DATA_W-1:0] avr_data,
  input  logic [6:0]        avr_ctrl,
  input  logic              avr_counter_n,
  input  logic              avr_we_n,
  input  logic              avr_oe_n,
  input  logic              avr_si,
  input  logic              avr_sreg_en_n,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ce_n,
  input  logic [ADDR_W-1:0] snes_addr,
  inout  wire  [DATA_W-1:0] snes_data,
  output logic [3:0]        debug
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_RD_SETUP  = 3'b001,
    ST_RD_LATCH  = 3'b010,
    ST_RD_OUT    = 3'b011,
    ST_WR_LATCH  = 3'b100,
    ST_WR_STROBE = 3'b101,
    ST_WR_HOLD   = 3'b110
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sclk_q;
  logic              cnt_prev_q;
  logic              snes_mode_q, snes_mode_d;
  logic [DATA_W-1:0] buf_sram_q, buf_avr_q;
  logic              sram_drive_q;
  logic              sram_oe_q, sram_we_q, sram_ce_q;

  logic eff_sreg_en_n, eff_si, eff_oe_n, eff_we_n, eff_counter_n;
  logic snes_set, snes_clr;
  logic ctrl_unused;

  assign ctrl_unused = ^avr_ctrl[6:4];

  // Command mode replaces every discrete pin; only the decoded control leaves idle.
  always_comb begin
    eff_sreg_en_n = 1'b1;
    eff_si        = 1'b0;
    eff_oe_n      = 1'b1;
    eff_we_n      = 1'b1;
    eff_counter_n = 1'b1;
    snes_set      = 1'b0;
    snes_clr      = 1'b0;
    if (!avr_ctrl[0]) begin
      eff_sreg_en_n = avr_sreg_en_n;
      eff_si        = avr_si;
      eff_oe_n      = avr_oe_n;
      eff_we_n      = avr_we_n;
      eff_counter_n = avr_counter_n;
    end else begin
      case (avr_ctrl[3:1])
        3'b001:  eff_sreg_en_n = 1'b0;
        3'b010:  begin eff_sreg_en_n = 1'b0; eff_si = 1'b1; end
        3'b011:  eff_oe_n = 1'b0;
        3'b100:  eff_we_n = 1'b0;
        3'b101:  eff_counter_n = 1'b0;
        3'b110:  snes_set = 1'b1;
        3'b111:  snes_clr = 1'b1;
        default: ;
      endcase
    end
  end

  // Shift on the sclk rising half; it takes priority over a counter step.
  always_comb begin
    addr_d = addr_q;
    if (!sclk_q && !eff_sreg_en_n)
      addr_d = {addr_q[ADDR_W-2:0], eff_si};
    else if (cnt_prev_q && !eff_counter_n)
      addr_d = addr_q + ADDR_W'(1);
  end

  always_comb begin
    snes_mode_d = snes_mode_q;
    if (snes_set)
      snes_mode_d = 1'b1;
    else if (snes_clr)
      snes_mode_d = 1'b0;
  end

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      addr_q      <= '0;
      sclk_q      <= 1'b0;
      cnt_prev_q  <= 1'b1;
      snes_mode_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      sclk_q      <= ~sclk_q;
      cnt_prev_q  <= eff_counter_n;
      snes_mode_q <= snes_mode_d;
    end
  end

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      state_q      <= ST_IDLE;
      sram_oe_q    <= 1'b1;
      sram_we_q    <= 1'b1;
      sram_ce_q    <= 1'b1;
      sram_drive_q <= 1'b0;
      buf_sram_q   <= '0;
      buf_avr_q    <= '0;
    end else if (snes_mode_q) begin
      state_q      <= ST_IDLE;
      sram_oe_q    <= 1'b1;
      sram_we_q    <= 1'b1;
      sram_ce_q    <= 1'b1;
      sram_drive_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sram_drive_q <= 1'b0;
          if (!eff_oe_n && eff_we_n) begin
            state_q   <= ST_RD_SETUP;
            sram_ce_q <= 1'b0;
            sram_oe_q <= 1'b0;
          end else if (!eff_we_n && eff_oe_n) begin
            state_q <= ST_WR_LATCH;
          end
        end
        ST_RD_SETUP: state_q <= ST_RD_LATCH;
        ST_RD_LATCH: begin
          buf_sram_q <= sram_data;
          state_q    <= ST_RD_OUT;
          sram_ce_q  <= 1'b1;
          sram_oe_q  <= 1'b1;
        end
        ST_RD_OUT: state_q <= ST_IDLE;
        ST_WR_LATCH: begin
          buf_avr_q    <= avr_data;
          state_q      <= ST_WR_STROBE;
          sram_drive_q <= 1'b1;
          sram_ce_q    <= 1'b0;
          sram_we_q    <= 1'b0;
        end
        // Data stays driven through WR_HOLD so it outlasts the we_n rising edge.
        ST_WR_STROBE: begin
          state_q   <= ST_WR_HOLD;
          sram_ce_q <= 1'b1;
          sram_we_q <= 1'b1;
        end
        ST_WR_HOLD: begin
          state_q      <= ST_IDLE;
          sram_drive_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          sram_oe_q    <= 1'b1;
          sram_we_q    <= 1'b1;
          sram_ce_q    <= 1'b1;
          sram_drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign sram_oe_n = sram_oe_q;
  assign sram_we_n = sram_we_q;
  assign sram_ce_n = sram_ce_q;
  assign sram_addr = snes_mode_q ? snes_addr : addr_q;

  assign avr_data  = (!eff_oe_n && eff_we_n) ? buf_sram_q : 'z;
  assign sram_data = sram_drive_q ? buf_avr_q : 'z;
  assign snes_data = snes_mode_q ? buf_sram_q : 'z;

`ifdef CPLD_DEBUG_EN
  logic conflict_q;

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n)
      conflict_q <= 1'b0;
    else
      conflict_q <= !eff_oe_n && !eff_we_n;
  end

  assign debug = {conflict_q, state_q};
`else
  assign debug = 4'b0000;
`endif

endmodule

// File: tb/tb_quickdev_cpld_core.sv
// Directed bench for quickdev_cpld_core: vector table for address/command decode plus bus sequences.
module tb_quickdev_cpld_core;

  logic        avr_clk = 1'b0;
  logic        avr_reset_n;
  logic [6:0]  avr_ctrl;
  logic        avr_counter_n, avr_we_n, avr_oe_n, avr_si, avr_sreg_en_n;
  logic [20:0] sram_addr;
  logic        sram_oe_n, sram_we_n, sram_ce_n;
  logic [20:0] snes_addr;
  logic [3:0]  debug;
  wire  [7:0]  avr_data, sram_data, snes_data;

  logic       avr_drv_en, sram_drv_en, snes_drv_en;
  logic [7:0] avr_drv_val, sram_drv_val, snes_drv_val;

  assign avr_data  = avr_drv_en  ? avr_drv_val  : 'z;
  assign sram_data = sram_drv_en ? sram_drv_val : 'z;
  assign snes_data = snes_drv_en ? snes_drv_val : 'z;

  quickdev_cpld_core dut (
    .avr_clk       (avr_clk),
    .avr_reset_n   (avr_reset_n),
    .avr_data      (avr_data),
    .avr_ctrl      (avr_ctrl),
    .avr_counter_n (avr_counter_n),
    .avr_we_n      (avr_we_n),
    .avr_oe_n      (avr_oe_n),
    .avr_si        (avr_si),
    .avr_sreg_en_n (avr_sreg_en_n),
    .sram_data     (sram_data),
    .sram_addr     (sram_addr),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_ce_n     (sram_ce_n),
    .snes_addr     (snes_addr),
    .snes_data     (snes_data),
    .debug         (debug)
  );

  always #5 avr_clk = ~avr_clk;

  typedef struct {
    logic [6:0]  ctrl;
    logic        cnt_n;
    logic        en_n;
    logic        si;
    logic [20:0] exp_addr;
  } vec_t;

  vec_t vecs[13];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge avr_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    avr_reset_n = 1'b0;
    repeat (3) tick();
    avr_reset_n = 1'b1;
  endtask

  task automatic shift_bits(input logic [20:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      avr_si        = v[i];
      avr_sreg_en_n = 1'b0;
      tick();
      tick();
    end
    avr_sreg_en_n = 1'b1;
    avr_si        = 1'b0;
  endtask

  task automatic counter_pulse();
    avr_counter_n = 1'b0;
    tick();
    tick();
    avr_counter_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic seen;
    int   lo_oe, lo_ce;

    // ctrl, counter_n, sreg_en_n, si, expected address after two clocks (from reset value 0)
    vecs[0]  = '{7'b0000000, 1'b1, 1'b0, 1'b1, 21'h000001};
    vecs[1]  = '{7'b0000000, 1'b1, 1'b0, 1'b0, 21'h000002};
    vecs[2]  = '{7'b0000011, 1'b1, 1'b1, 1'b0, 21'h000004};
    vecs[3]  = '{7'b0000101, 1'b1, 1'b1, 1'b0, 21'h000009};
    vecs[4]  = '{7'b0000000, 1'b1, 1'b1, 1'b1, 21'h000009};
    vecs[5]  = '{7'b1111110, 1'b1, 1'b1, 1'b1, 21'h000009};
    vecs[6]  = '{7'b1110011, 1'b1, 1'b1, 1'b0, 21'h000012};
    vecs[7]  = '{7'b0000001, 1'b0, 1'b0, 1'b1, 21'h000012};
    vecs[8]  = '{7'b0001011, 1'b1, 1'b1, 1'b0, 21'h000013};
    vecs[9]  = '{7'b0000000, 1'b1, 1'b1, 1'b0, 21'h000013};
    vecs[10] = '{7'b0000000, 1'b0, 1'b1, 1'b0, 21'h000014};
    vecs[11] = '{7'b0001100, 1'b1, 1'b1, 1'b0, 21'h000014};
    vecs[12] = '{7'b0000000, 1'b1, 1'b0, 1'b1, 21'h000029};

    avr_reset_n   = 1'b0;
    avr_ctrl      = 7'b0;
    avr_counter_n = 1'b1;
    avr_we_n      = 1'b1;
    avr_oe_n      = 1'b1;
    avr_si        = 1'b0;
    avr_sreg_en_n = 1'b1;
    snes_addr     = 21'h155AA3;
    avr_drv_en    = 1'b0;
    sram_drv_en   = 1'b0;
    snes_drv_en   = 1'b0;
    avr_drv_val   = 8'h00;
    sram_drv_val  = 8'h00;
    snes_drv_val  = 8'h00;

    do_reset();
    check("reset_addr", sram_addr, 21'h0);
    check("reset_strobes", {sram_oe_n, sram_we_n, sram_ce_n}, 3'b111);
    check("reset_debug", debug, 4'h0);

    for (int v = 0; v < 13; v++) begin
      avr_ctrl      = vecs[v].ctrl;
      avr_counter_n = vecs[v].cnt_n;
      avr_sreg_en_n = vecs[v].en_n;
      avr_si        = vecs[v].si;
      tick();
      tick();
      $display("vec %0d ctrl=%b cnt_n=%b en_n=%b si=%b sram_addr=0x%06h", v, vecs[v].ctrl,
               vecs[v].cnt_n, vecs[v].en_n, vecs[v].si, sram_addr);
      check($sformatf("vec%0d_addr", v), sram_addr, vecs[v].exp_addr);
      check($sformatf("vec%0d_strobes", v), {sram_oe_n, sram_we_n, sram_ce_n}, 3'b111);
    end
    avr_ctrl = 7'b0; avr_counter_n = 1'b1; avr_sreg_en_n = 1'b1; avr_si = 1'b0;

    do_reset();
    shift_bits(21'h004CCF, 15);
    tick();
    check("shift_4ccf", sram_addr, 21'h004CCF);
    counter_pulse();
    check("count_4cd0", sram_addr, 21'h004CD0);

    do_reset();
    shift_bits(21'h1FFFFF, 21);
    tick();
    check("shift_all_ones", sram_addr, 21'h1FFFFF);
    counter_pulse();
    check("count_wrap", sram_addr, 21'h000000);

    // Read: strobes low 2 clocks, data visible within 4 clocks, then a fresh value while oe held
    sram_drv_en = 1'b1; sram_drv_val = 8'hAA;
    avr_oe_n = 1'b0;
    seen = 1'b0; lo_oe = 0; lo_ce = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (!sram_oe_n) lo_oe++;
      if (!sram_ce_n) lo_ce++;
      if (avr_data == 8'hAA) seen = 1'b1;
    end
    $display("read 0xAA: seen=%0b oe_low=%0d ce_low=%0d", seen, lo_oe, lo_ce);
    check("rd_aa_seen", seen, 1);
    check("rd_oe_pulse", lo_oe, 2);
    check("rd_ce_pulse", lo_ce, 2);
    sram_drv_val = 8'hBB;
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      tick();
      if (avr_data == 8'hBB) seen = 1'b1;
    end
    check("rd_bb_seen", seen, 1);
    avr_oe_n = 1'b1;
    tick();
    tick();
    avr_drv_en = 1'b1; avr_drv_val = 8'h00;
    #1;
    check("avr_release", avr_data, 8'h00);
    check("rd_idle_strobes", {sram_oe_n, sram_we_n, sram_ce_n}, 3'b111);

    // Write: we low exactly one clock, data held one more clock, then released
    sram_drv_en = 1'b0;
    avr_drv_val = 8'hEE;
    avr_we_n = 1'b0;
    tick();
    avr_we_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      tick();
      if (!sram_we_n) seen = 1'b1;
    end
    $display("write 0xEE: we_seen=%0b sram_data=0x%02h", seen, sram_data);
    check("wr_we_seen", seen, 1);
    check("wr_data", sram_data, 8'hEE);
    check("wr_ce", sram_ce_n, 1'b0);
    tick();
    check("wr_we_rise", sram_we_n, 1'b1);
    check("wr_hold", sram_data, 8'hEE);
    tick();
    sram_drv_en = 1'b1; sram_drv_val = 8'h00;
    #1;
    check("wr_release", sram_data, 8'h00);

    // Command-mode read (opcode 011)
    avr_drv_en = 1'b0;
    sram_drv_val = 8'h3C;
    avr_ctrl = 7'b0000111;
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      tick();
      if (avr_data == 8'h3C) seen = 1'b1;
    end
    $display("cmd read 0x3C: seen=%0b", seen);
    check("cmd_rd_seen", seen, 1);
    avr_ctrl = 7'b0;
    repeat (3) tick();

    // Command-mode write (opcode 100)
    sram_drv_en = 1'b0;
    avr_drv_en = 1'b1; avr_drv_val = 8'h96;
    avr_ctrl = 7'b0001001;
    tick();
    avr_ctrl = 7'b0;
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      tick();
      if (!sram_we_n) seen = 1'b1;
    end
    $display("cmd write 0x96: we_seen=%0b sram_data=0x%02h", seen, sram_data);
    check("cmd_wr_seen", seen, 1);
    check("cmd_wr_data", sram_data, 8'h96);
    tick();
    tick();
    sram_drv_en = 1'b1; sram_drv_val = 8'h00;

    // oe and we both low: no bus cycle, conflict flag when debug is built in
    avr_drv_val = 8'h00;
    avr_oe_n = 1'b0; avr_we_n = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("conflict_strobes%0d", t), {sram_oe_n, sram_we_n, sram_ce_n}, 3'b111);
    end
    check("conflict_avr_free", avr_data, 8'h00);
`ifdef CPLD_DEBUG_EN
    check("conflict_debug", debug, 4'b1000);
`else
    check("conflict_debug", debug, 4'b0000);
`endif
    avr_oe_n = 1'b1; avr_we_n = 1'b1;
    tick();
    tick();

    // SNES passthrough
    avr_ctrl = 7'b0001101;
    tick();
    avr_ctrl = 7'b0;
    tick();
    $display("snes on: sram_addr=0x%06h snes_data=0x%02h", sram_addr, snes_data);
    check("snes_addr", sram_addr, 21'h155AA3);
    check("snes_data", snes_data, 8'h3C);
    avr_drv_en = 1'b0;
    avr_oe_n = 1'b0;
    lo_oe = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (!sram_oe_n || !sram_ce_n) lo_oe++;
    end
    check("snes_no_strobe", lo_oe, 0);
    avr_oe_n = 1'b1;
    tick();
    avr_ctrl = 7'b0001111;
    tick();
    avr_ctrl = 7'b0;
    tick();
    check("snes_off_addr", sram_addr, 21'h000000);
    snes_drv_en = 1'b1; snes_drv_val = 8'h00;
    #1;
    check("snes_release", snes_data, 8'h00);

    // Reset asserted while in WR_STROBE aborts the write
    sram_drv_en = 1'b0;
    avr_drv_en = 1'b1; avr_drv_val = 8'h5A;
    avr_we_n = 1'b0;
    tick();
    avr_we_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      tick();
      if (!sram_we_n) seen = 1'b1;
    end
    check("abort_we_seen", seen, 1);
    avr_reset_n = 1'b0;
    tick();
    sram_drv_en = 1'b1; sram_drv_val = 8'h00;
    #1;
    $display("reset in WR_STROBE: we_n=%0b ce_n=%0b sram_data=0x%02h", sram_we_n, sram_ce_n, sram_data);
    check("abort_strobes", {sram_oe_n, sram_we_n, sram_ce_n}, 3'b111);
    check("abort_release", sram_data, 8'h00);
    avr_reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
